// File: rtl/flexbex_multdiv_param.sv
// Iterative multiplier/divider: KW x KW partial products per cycle for MUL/MULH,
// restoring division for DIV/REM when FLEXBEX_MULTDIV_DIV_EN is defined.
module flexbex_multdiv_param #(
  parameter int XLEN = 32,
  parameter int KW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      operator_i,
  input  logic [1:0]      signed_mode_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int N = XLEN / KW;
  localparam logic [1:0] NM1 = 2'(N - 1);
  localparam logic [1:0] OP_MUL = 2'd0, OP_MULH = 2'd1, OP_DIV = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;
  state_e state_q, state_d;

  logic [1:0]        op_q;
  logic              sa_q, sb_q;
  logic [XLEN-1:0]   a_mag_q, b_mag_q, result_q;
  logic [2*XLEN-1:0] acc_q;
  logic [1:0]        i_q, j_q;

  logic              accept, sa_in, sb_in, mul_last;
  logic [XLEN-1:0]   a_mag_in, b_mag_in, fix_res;
  logic [1:0]        j_lim;
  logic [KW-1:0]     a_k, b_k;
  logic [2*KW-1:0]   pp;
  logic [2*XLEN-1:0] pp_ext, prod;

  assign accept   = valid_i & (state_q == S_IDLE);
  assign sa_in    = op_a_i[XLEN-1] & signed_mode_i[0];
  assign sb_in    = op_b_i[XLEN-1] & signed_mode_i[1];
  assign a_mag_in = sa_in ? -op_a_i : op_a_i;
  assign b_mag_in = sb_in ? -op_b_i : op_b_i;

  // MUL only needs the lower triangle (i+j<N); MULH walks the full square
  assign j_lim    = (op_q == OP_MUL) ? NM1 - i_q : NM1;
  assign mul_last = (i_q == NM1) && (j_q == j_lim);
  assign a_k      = KW'(a_mag_q >> (KW * int'(i_q)));
  assign b_k      = KW'(b_mag_q >> (KW * int'(j_q)));
  assign pp       = {{KW{1'b0}}, a_k} * {{KW{1'b0}}, b_k};
  assign pp_ext   = (2*XLEN)'(pp) << (KW * (int'(i_q) + int'(j_q)));
  assign prod     = (sa_q ^ sb_q) ? -acc_q : acc_q;

`ifdef FLEXBEX_MULTDIV_DIV_EN
  localparam int CW = $clog2(XLEN);
  logic [CW-1:0]     cnt_q;
  logic              div0_q;
  logic [XLEN-1:0]   a_raw_q;
  logic [XLEN:0]     rem_sh, diff;
  logic              q_bit;
  logic [2*XLEN-1:0] acc_div;

  // acc_q holds {remainder, dividend/quotient}; one quotient bit shifts in per cycle
  assign rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, b_mag_q};
  assign q_bit   = ~diff[XLEN];
  assign acc_div = {q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0], acc_q[XLEN-2:0], q_bit};
`endif

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:  fix_res = prod[XLEN-1:0];
      OP_MULH: fix_res = prod[2*XLEN-1:XLEN];
      default: begin
`ifdef FLEXBEX_MULTDIV_DIV_EN
        if (div0_q)
          fix_res = (op_q == OP_DIV) ? '1 : a_raw_q;
        else if (op_q == OP_DIV)
          fix_res = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        else
          fix_res = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
`else
        fix_res = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (valid_i) begin
`ifdef FLEXBEX_MULTDIV_DIV_EN
        if (operator_i[1]) state_d = (op_b_i == '0) ? S_FIX : S_DIV;
`else
        if (operator_i[1]) state_d = S_FIX;
`endif
        else               state_d = S_MUL;
      end
      S_MUL:  if (mul_last) state_d = S_FIX;
`ifdef FLEXBEX_MULTDIV_DIV_EN
      S_DIV:  if (cnt_q == '0) state_d = S_FIX;
`else
      S_DIV:  state_d = S_FIX;
`endif
      S_FIX:  state_d = S_DONE;
      S_DONE: if (ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o  = (state_q == S_IDLE);
    valid_o  = (state_q == S_DONE);
    result_o = valid_o ? result_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      result_q <= '0;
`ifdef FLEXBEX_MULTDIV_DIV_EN
      cnt_q    <= '0;
      div0_q   <= 1'b0;
      a_raw_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          op_q    <= operator_i;
          sa_q    <= sa_in;
          sb_q    <= sb_in;
          a_mag_q <= a_mag_in;
          b_mag_q <= b_mag_in;
          acc_q   <= operator_i[1] ? {{XLEN{1'b0}}, a_mag_in} : '0;
          i_q     <= '0;
          j_q     <= '0;
`ifdef FLEXBEX_MULTDIV_DIV_EN
          cnt_q   <= CW'(XLEN - 1);
          div0_q  <= (op_b_i == '0);
          a_raw_q <= op_a_i;
`endif
        end
        S_MUL: begin
          acc_q <= acc_q + pp_ext;
          if (j_q == j_lim) begin
            j_q <= '0;
            i_q <= i_q + 2'd1;
          end else begin
            j_q <= j_q + 2'd1;
          end
        end
`ifdef FLEXBEX_MULTDIV_DIV_EN
        S_DIV: begin
          acc_q <= acc_div;
          cnt_q <= cnt_q - 1'b1;
        end
`endif
        S_FIX:  result_q <= fix_res;
        S_DONE: if (ready_i) result_q <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flexbex_multdiv_param.sv
// Directed and random checks of flexbex_multdiv_param (XLEN=32, KW=16) with a
// result/latency scoreboard; DIV/REM expectations follow FLEXBEX_MULTDIV_DIV_EN.
module tb_flexbex_multdiv_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  operator_i = '0;
  logic [1:0]  signed_mode_i = '0;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  flexbex_multdiv_param #(.XLEN(32), .KW(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .operator_i(operator_i), .signed_mode_i(signed_mode_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [1:0] mode,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      ea, eb;
    logic [63:0] p;
    ea = mode[0] ? longint'($signed(a)) : longint'(a);
    eb = mode[1] ? longint'($signed(b)) : longint'(b);
    case (op)
      2'd0: begin p = ea * eb; return p[31:0]; end
      2'd1: begin p = ea * eb; return p[63:32]; end
      default: begin
`ifdef FLEXBEX_MULTDIV_DIV_EN
        if (b == 32'd0) return (op == 2'd2) ? 32'hFFFF_FFFF : a;
        p = (op == 2'd2) ? ea / eb : ea % eb;
        return p[31:0];
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    case (op)
      2'd0: return 4;
      2'd1: return 5;
`ifdef FLEXBEX_MULTDIV_DIV_EN
      default: return (b == 32'd0) ? 1 : 33;
`else
      default: return 1;
`endif
    endcase
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the result, compare against the scoreboard
  task automatic run_op(input string tag, input logic [1:0] op, input logic [1:0] mode,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_l);
    exp_t e;
    int   lat;
    e.res = exp_res;
    e.lat = exp_l;
    sb_q.push_back(e);
    check32({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
    valid_i = 1'b1; operator_i = op; signed_mode_i = mode; op_a_i = a; op_b_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 0;
    while (valid_o !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    check32({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    check32({tag, "_res"}, result_o, e.res);
    check32({tag, "_lat"}, lat, e.lat);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0]  rop, rmode;
    logic [31:0] ra, rb, held;

    #1;
    check32("rst_ready", {31'd0, ready_o}, 32'd1);
    check32("rst_valid", {31'd0, valid_o}, 32'd0);
    check32("rst_result", result_o, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_ffff", 2'd0, 2'b00, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 4);
    run_op("mulh_ss", 2'd1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 5);
    run_op("mulh_uu", 2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    run_op("mulh_su", 2'd1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    run_op("mul_neg", 2'd0, 2'b11, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 4);
`ifdef FLEXBEX_MULTDIV_DIV_EN
    run_op("div_m7_2", 2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2", 2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("rem_7_m2", 2'd3, 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("div_ovf", 2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("rem_ovf", 2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    run_op("div_zero", 2'd2, 2'b00, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_zero", 2'd3, 2'b00, 32'd100, 32'd0, 32'd100, 1);
`else
    run_op("div_off", 2'd2, 2'b00, 32'd100, 32'd7, 32'd0, 1);
    run_op("rem_off", 2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd0, 1);
`endif

    for (int k = 0; k < 12; k++) begin
      rop   = 2'($urandom_range(0, 3));
      rmode = 2'($urandom_range(0, 3));
      ra    = $urandom;
      rb    = (k == 5) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      run_op("rand", rop, rmode, ra, rb, model(rop, rmode, ra, rb), exp_lat(rop, rb));
    end

    // Back-pressure: result must hold and new requests must be ignored
    ready_i = 1'b0;
    valid_i = 1'b1; operator_i = 2'd0; signed_mode_i = 2'b00; op_a_i = 32'd6; op_b_i = 32'd7;
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1; end
    check32("stall_valid", {31'd0, valid_o}, 32'd1);
    held = result_o;
    check32("stall_res", held, 32'd42);
    valid_i = 1'b1; op_a_i = 32'd9; op_b_i = 32'd9;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check32("stall_hold", result_o, 32'd42);
      check32("stall_rdy", {31'd0, ready_o}, 32'd0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    check32("release_rdy", {31'd0, ready_o}, 32'd1);
    check32("release_vld", {31'd0, valid_o}, 32'd0);

    // Reset in the middle of a long operation
`ifdef FLEXBEX_MULTDIV_DIV_EN
    valid_i = 1'b1; operator_i = 2'd2; signed_mode_i = 2'b00; op_a_i = 32'd1000; op_b_i = 32'd7;
`else
    valid_i = 1'b1; operator_i = 2'd1; signed_mode_i = 2'b00; op_a_i = 32'hFFFF_FFFF; op_b_i = 32'hFFFF_FFFF;
`endif
    @(posedge clk); #1;
    valid_i = 1'b0;
`ifdef FLEXBEX_MULTDIV_DIV_EN
    for (int c = 0; c < 10; c++) begin @(posedge clk); #1; end
`else
    for (int c = 0; c < 2; c++) begin @(posedge clk); #1; end
`endif
    rst_n = 1'b0;
    #1;
    check32("midrst_ready", {31'd0, ready_o}, 32'd1);
    check32("midrst_valid", {31'd0, valid_o}, 32'd0);
    check32("midrst_res", result_o, 32'd0);
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (c % 10 == 0) check32("post_rst_quiet", {31'd0, valid_o}, 32'd0);
    end
    run_op("mul_3x5", 2'd0, 2'b00, 32'd3, 32'd5, 32'd15, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
